// File: rtl/instr_assembler_if.sv
// Fetch-beat / instruction handshake bundle for instr_assembler.
// master drives beats, flush and ack; slave is the assembler itself.
interface instr_assembler_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned BEATS  = 2,
    parameter int unsigned OPC_W  = 3
);
    localparam int unsigned INSTR_W = DATA_W * BEATS;

    logic [DATA_W-1:0]        data;
    logic                     data_valid;
    logic                     data_ready;
    logic                     flush;
    logic [INSTR_W-1:0]       instr;
    logic [OPC_W-1:0]         opcode;
    logic [INSTR_W-OPC_W-1:0] operand;
    logic                     instr_valid;
    logic                     instr_ack;
    logic                     abort_err;

    modport master (
        output data, data_valid, flush, instr_ack,
        input  data_ready, instr, opcode, operand, instr_valid, abort_err
    );

    modport slave (
        input  data, data_valid, flush, instr_ack,
        output data_ready, instr, opcode, operand, instr_valid, abort_err
    );
endinterface

// File: rtl/instr_assembler.sv
// Collects BEATS data beats into one instruction word and holds it for decode.
// Optional stall timeout for partial fetches is enabled by defining INSTR_TIMEOUT_EN.
module instr_assembler #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BEATS     = 2,
    parameter int unsigned OPC_W     = 3,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned TIMEOUT   = 4
) (
    input logic             clk,
    input logic             rst,
    instr_assembler_if.slave bus
);
    localparam int unsigned INSTR_W = DATA_W * BEATS;
    localparam int unsigned CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (BEATS < 1 || OPC_W >= INSTR_W || TIMEOUT < 1) begin : g_param_check
        $error("instr_assembler: invalid parameter combination");
    end

    typedef enum logic [0:0] {StFill, StHold} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0]   slot;
    logic               accept;

`ifdef INSTR_TIMEOUT_EN
    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              abort_q, abort_d;
`endif

    assign accept = bus.data_valid && (state_q == StFill);
    // Slice the current beat lands in depends on beat order.
    assign slot   = MSB_FIRST ? (CNT_W'(BEATS - 1) - cnt_q) : cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
`ifdef INSTR_TIMEOUT_EN
        tcnt_d  = tcnt_q;
        abort_d = 1'b0;
`endif
        if (bus.flush) begin
            state_d = StFill;
            cnt_d   = '0;
`ifdef INSTR_TIMEOUT_EN
            tcnt_d  = '0;
`endif
        end else begin
            unique case (state_q)
                StFill: begin
                    if (accept) begin
                        for (int unsigned i = 0; i < BEATS; i++) begin
                            if (slot == CNT_W'(i)) instr_d[i*DATA_W +: DATA_W] = bus.data;
                        end
                        if (cnt_q == CNT_W'(BEATS - 1)) begin
                            cnt_d   = '0;
                            state_d = StHold;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
`ifdef INSTR_TIMEOUT_EN
                        tcnt_d = '0;
                    end else if (cnt_q != '0) begin
                        if (tcnt_q == TCNT_W'(TIMEOUT)) begin
                            cnt_d   = '0;
                            tcnt_d  = '0;
                            abort_d = 1'b1;
                        end else begin
                            tcnt_d = tcnt_q + 1'b1;
                        end
`endif
                    end
                end
                StHold: begin
                    if (bus.instr_ack) state_d = StFill;
                end
                default: state_d = StFill;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFill;
            cnt_q   <= '0;
            instr_q <= '0;
`ifdef INSTR_TIMEOUT_EN
            tcnt_q  <= '0;
            abort_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
`ifdef INSTR_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
            abort_q <= abort_d;
`endif
        end
    end

    assign bus.data_ready  = (state_q == StFill);
    assign bus.instr_valid = (state_q == StHold);
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[INSTR_W-1 -: OPC_W];
    assign bus.operand     = instr_q[INSTR_W-OPC_W-1:0];
`ifdef INSTR_TIMEOUT_EN
    assign bus.abort_err   = abort_q;
`else
    assign bus.abort_err   = 1'b0;
`endif
endmodule

// File: tb/tb_instr_assembler.sv
// Randomized bench for instr_assembler: two configurations (2 beats MSB-first, 4 beats
// LSB-first) checked every cycle against a queue-free behavioural model plus directed spot checks.
module tb_instr_assembler;
    localparam int unsigned TIMEOUT = 4;
`ifdef INSTR_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_assembler_if #(.DATA_W(8), .BEATS(2), .OPC_W(3)) bus_a ();
    instr_assembler_if #(.DATA_W(8), .BEATS(4), .OPC_W(3)) bus_b ();

    instr_assembler #(
        .DATA_W(8), .BEATS(2), .OPC_W(3), .MSB_FIRST(1'b1), .TIMEOUT(TIMEOUT)
    ) u_dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave)
    );

    instr_assembler #(
        .DATA_W(8), .BEATS(4), .OPC_W(3), .MSB_FIRST(1'b0), .TIMEOUT(TIMEOUT)
    ) u_dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave)
    );

    typedef struct {
        bit          hold;
        int          cnt;
        int          tcnt;
        bit          abort;
        logic [31:0] instr;
    } model_t;

    model_t ma, mb;
    int checks   = 0;
    int failures = 0;
    int abort_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural rules of the block, one clock at a time.
    function automatic model_t step(input model_t s, input int beats, input bit msb_first,
                                    input logic [7:0] d, input bit r, input bit f,
                                    input bit dv, input bit ack);
        model_t n = s;
        int pos;
        n.abort = 1'b0;
        if (r) begin
            n.hold = 1'b0; n.cnt = 0; n.tcnt = 0; n.instr = '0;
        end else if (f) begin
            n.hold = 1'b0; n.cnt = 0; n.tcnt = 0;
        end else if (s.hold) begin
            if (ack) n.hold = 1'b0;
        end else if (dv) begin
            pos = msb_first ? (beats - 1 - s.cnt) : s.cnt;
            n.instr[pos*8 +: 8] = d;
            n.cnt  = s.cnt + 1;
            n.tcnt = 0;
            if (n.cnt == beats) begin
                n.cnt  = 0;
                n.hold = 1'b1;
            end
        end else if (TimeoutEn && s.cnt > 0) begin
            if (s.tcnt == TIMEOUT) begin
                n.cnt = 0; n.tcnt = 0; n.abort = 1'b1;
            end else begin
                n.tcnt = s.tcnt + 1;
            end
        end
        return n;
    endfunction

    task automatic compare_a();
        check("a_instr", 32'(bus_a.instr), ma.instr & 32'hFFFF);
        check("a_valid", 32'(bus_a.instr_valid), 32'(ma.hold));
        check("a_ready", 32'(bus_a.data_ready), 32'(!ma.hold));
        check("a_opcode", 32'(bus_a.opcode), (ma.instr & 32'hFFFF) >> 13);
        check("a_operand", 32'(bus_a.operand), ma.instr & 32'h1FFF);
        check("a_abort", 32'(bus_a.abort_err), 32'(ma.abort));
    endtask

    task automatic compare_b();
        check("b_instr", bus_b.instr, mb.instr);
        check("b_valid", 32'(bus_b.instr_valid), 32'(mb.hold));
        check("b_ready", 32'(bus_b.data_ready), 32'(!mb.hold));
        check("b_opcode", 32'(bus_b.opcode), mb.instr >> 29);
        check("b_operand", 32'(bus_b.operand), mb.instr & 32'h1FFF_FFFF);
        check("b_abort", 32'(bus_b.abort_err), 32'(mb.abort));
    endtask

    task automatic tick(input bit r, input bit f, input bit dv, input logic [7:0] d,
                        input bit ack);
        rst = r;
        bus_a.flush = f; bus_a.data_valid = dv; bus_a.data = d; bus_a.instr_ack = ack;
        bus_b.flush = f; bus_b.data_valid = dv; bus_b.data = d; bus_b.instr_ack = ack;
        @(posedge clk);
        ma = step(ma, 2, 1'b1, d, r, f, dv, ack);
        mb = step(mb, 4, 1'b0, d, r, f, dv, ack);
        #1;
        compare_a();
        compare_b();
        if (bus_a.abort_err) abort_seen++;
    endtask

    initial begin
        int idle_run;
        ma = '{hold: 1'b0, cnt: 0, tcnt: 0, abort: 1'b0, instr: '0};
        mb = ma;
        abort_seen = 0;

        tick(1, 0, 0, 8'h00, 0);
        tick(1, 0, 1, 8'hEE, 1);
        check("rst_ready", 32'(bus_a.data_ready), 32'd1);

        // Two-beat fetch, MSB first.
        tick(0, 0, 1, 8'hA5, 0);
        tick(0, 0, 1, 8'h3C, 0);
        check("dir_instr", 32'(bus_a.instr), 32'hA53C);
        check("dir_opcode", 32'(bus_a.opcode), 32'd5);
        check("dir_operand", 32'(bus_a.operand), 32'h053C);
        check("dir_ready", 32'(bus_a.data_ready), 32'd0);
        for (int i = 0; i < 5; i++) tick(0, 0, 1, 8'hFF, 0);
        check("hold_instr", 32'(bus_a.instr), 32'hA53C);
        tick(0, 0, 0, 8'h00, 1);
        check("ack_valid", 32'(bus_a.instr_valid), 32'd0);
        check("ack_ready", 32'(bus_a.data_ready), 32'd1);

        // Four-beat LSB-first with a 3-cycle gap between beats 2 and 3.
        tick(1, 0, 0, 8'h00, 0);
        tick(0, 0, 1, 8'h11, 0);
        tick(0, 0, 1, 8'h22, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 8'h00, 0);
        tick(0, 0, 1, 8'h33, 0);
        tick(0, 0, 1, 8'h44, 0);
        check("b_gap_instr", bus_b.instr, 32'h4433_2211);
        check("b_gap_valid", 32'(bus_b.instr_valid), 32'd1);

        // Flush wins over a simultaneous beat.
        tick(1, 0, 0, 8'h00, 0);
        tick(0, 0, 1, 8'h12, 0);
        tick(0, 1, 1, 8'h34, 0);
        tick(0, 0, 1, 8'h56, 0);
        tick(0, 0, 1, 8'h78, 0);
        check("flush_instr", 32'(bus_a.instr), 32'h5678);

        // Stalled partial fetch.
        tick(1, 0, 0, 8'h00, 0);
        abort_seen = 0;
        tick(0, 0, 1, 8'h9A, 0);
        for (int i = 0; i < TIMEOUT + 3; i++) tick(0, 0, 0, 8'h00, 0);
        check("abort_pulses", 32'(abort_seen), TimeoutEn ? 32'd1 : 32'd0);
        tick(0, 0, 1, 8'hBC, 0);
        tick(0, 0, 1, 8'hDE, 0);
        if (TimeoutEn) check("post_abort_instr", 32'(bus_a.instr), 32'hBCDE);
        else check("held_partial_instr", 32'(bus_a.instr), 32'h9ABC);

        // Reset in HOLD and mid-FILL.
        tick(0, 0, 0, 8'h00, 0);
        tick(1, 0, 0, 8'h00, 0);
        check("rst_hold_instr", 32'(bus_a.instr), 32'd0);
        check("rst_hold_valid", 32'(bus_a.instr_valid), 32'd0);
        tick(0, 0, 1, 8'h77, 0);
        tick(1, 0, 1, 8'h88, 0);
        check("rst_fill_instr", 32'(bus_a.instr), 32'd0);
        check("rst_fill_ready", 32'(bus_a.data_ready), 32'd1);

        // Random traffic with bursts of idle cycles.
        idle_run = 0;
        for (int i = 0; i < 3000; i++) begin
            bit dv;
            if (idle_run > 0) begin
                dv = 1'b0;
                idle_run--;
            end else begin
                dv = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 24) == 0) idle_run = $urandom_range(1, 8);
            end
            tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0), dv,
                 8'($urandom), ($urandom_range(0, 2) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
